// File: rtl/dreg_bank_pkg.sv
// dreg_bank_pkg: shared types and default sizing for the lockable register bank.
// The lock FSM state type lives here so the top and any checkers see one definition.
package dreg_bank_pkg;

  localparam int DEFAULT_WIDTH    = 8;
  localparam int DEFAULT_CHANNELS = 4;

  // Lock FSM: UNLOCKED accepts writes; LOCKED and ARMING reject them.
  // ARMING is the first half of the two-cycle UNLOCK sequence.
  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_LOCKED   = 2'd1,
    ST_ARMING   = 2'd2
  } lock_state_t;

endpackage

// File: rtl/dreg_cell.sv
// dreg_cell: one storage channel of dreg_bank.
// Holds the data register and the sticky "value changed" flag. When
// DREG_BANK_PARITY_EN is defined it also stores an even-parity bit captured
// at write time and reports a mismatch against the live data; otherwise no
// parity state exists and perr_o is tied low.
module dreg_cell
  import dreg_bank_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_i,    // accepted write for this channel
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o,
  output logic             chg_o,
  output logic             perr_o
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             chg_q, chg_d;

  // Next-state: load on an accepted write; CHG sets only if the value differs.
  always_comb begin
    data_d = data_q;
    chg_d  = chg_q;
    if (wr_i) begin
      data_d = d_i;
      if (d_i != data_q) begin
        chg_d = 1'b1;
      end
    end
  end

  // Channel registers with synchronous reset taking priority over any write.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q <= '0;
      chg_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      chg_q  <= chg_d;
    end
  end

  assign q_o   = data_q;
  assign chg_o = chg_q;

`ifdef DREG_BANK_PARITY_EN
  logic par_q, par_d;

  // Parity bit is computed from the incoming data, not the stored data.
  always_comb begin
    par_d = par_q;
    if (wr_i) begin
      par_d = ^d_i;
    end
  end

  // Parity register; reset value 0 matches the parity of all-zero data.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end

  assign perr_o = par_q ^ (^data_q);
`else
  assign perr_o = 1'b0;
`endif

endmodule

// File: rtl/dreg_bank.sv
// dreg_bank: CHANNELS x WIDTH register bank with broadcast writes, a lock FSM
// gated by a two-cycle UNLOCK sequence, sticky change/violation flags and an
// optional per-channel parity check enabled by macro DREG_BANK_PARITY_EN.
//
// Write handshake: there is no ready/backpressure. A channel write is accepted
// on a rising edge exactly when RST=0, EN=1, WE[i]=1 and the FSM is UNLOCKED;
// the new value is visible on Q/Q_ALL right after that edge. Any write attempt
// (EN=1, WE!=0) while LOCKED or ARMING is dropped and sets VIOL.
module dreg_bank
  import dreg_bank_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int CHANNELS = DEFAULT_CHANNELS
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        EN,
  input  logic [CHANNELS-1:0]         WE,
  input  logic [WIDTH-1:0]            D,
  input  logic [$clog2(CHANNELS)-1:0] SEL,
  input  logic                        LOCK,
  input  logic                        UNLOCK,
  output logic [WIDTH-1:0]            Q,
  output logic [WIDTH*CHANNELS-1:0]   Q_ALL,
  output logic [CHANNELS-1:0]         CHG,
  output logic                        LOCKED,
  output logic                        VIOL,
  output logic                        PERR,
  output lock_state_t                 STATE_DBG  // lock FSM state, for observation only
);

  localparam int SEL_W = $clog2(CHANNELS);
  localparam logic [SEL_W:0] CH_LIM = (SEL_W + 1)'(CHANNELS);

  lock_state_t state_q, state_d;
  logic        viol_q, viol_d;
  logic        wr_ok;
  logic        sel_valid;

  logic [WIDTH-1:0] cell_q    [CHANNELS];
  logic             cell_perr [CHANNELS];

  // Lock FSM next state. LOCK always wins from LOCKED/ARMING; ARMING needs
  // UNLOCK on the immediately following cycle or it falls back to LOCKED.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_UNLOCKED: if (LOCK) state_d = ST_LOCKED;
      ST_LOCKED: begin
        if (LOCK)        state_d = ST_LOCKED;
        else if (UNLOCK) state_d = ST_ARMING;
        else             state_d = ST_LOCKED;
      end
      ST_ARMING: begin
        if (LOCK)        state_d = ST_LOCKED;
        else if (UNLOCK) state_d = ST_UNLOCKED;
        else             state_d = ST_LOCKED;
      end
      default: state_d = ST_UNLOCKED;
    endcase
  end

  // VIOL is sticky: any write attempt outside UNLOCKED sets it until reset.
  always_comb begin
    viol_d = viol_q;
    if (EN && (WE != '0) && (state_q != ST_UNLOCKED)) begin
      viol_d = 1'b1;
    end
  end

  // FSM and violation flag registers; reset returns to UNLOCKED from any state.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_UNLOCKED;
      viol_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      viol_q  <= viol_d;
    end
  end

  // A write in the same cycle as LOCK is still accepted since state_q is UNLOCKED.
  assign wr_ok = EN && (state_q == ST_UNLOCKED);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_cell
    dreg_cell #(
      .WIDTH (WIDTH)
    ) u_cell (
      .clk_i  (CLK),
      .rst_i  (RST),
      .wr_i   (wr_ok && WE[i]),
      .d_i    (D),
      .q_o    (cell_q[i]),
      .chg_o  (CHG[i]),
      .perr_o (cell_perr[i])
    );
    assign Q_ALL[i*WIDTH +: WIDTH] = cell_q[i];
  end

  // Out-of-range selects read as zero with no parity error.
  assign sel_valid = ({1'b0, SEL} < CH_LIM);
  assign Q         = sel_valid ? cell_q[SEL] : '0;
  assign PERR      = sel_valid ? cell_perr[SEL] : 1'b0;

  assign LOCKED    = (state_q != ST_UNLOCKED);
  assign VIOL      = viol_q;
  assign STATE_DBG = state_q;

endmodule

// File: tb/tb_dreg_bank.sv
// tb_dreg_bank: directed bench for dreg_bank at default sizing (8 x 4).
// Inputs change 1 ns after each rising edge; outputs are checked there too.
module tb_dreg_bank;
  import dreg_bank_pkg::*;

  localparam int W  = 8;
  localparam int CH = 4;

  logic            CLK = 1'b0;
  logic            RST;
  logic            EN;
  logic [CH-1:0]   WE;
  logic [W-1:0]    D;
  logic [1:0]      SEL;
  logic            LOCK;
  logic            UNLOCK;
  logic [W-1:0]    Q;
  logic [W*CH-1:0] Q_ALL;
  logic [CH-1:0]   CHG;
  logic            LOCKED;
  logic            VIOL;
  logic            PERR;
  lock_state_t     STATE_DBG;

  int checks   = 0;
  int failures = 0;

  // Clock
  always #5 CLK = ~CLK;

  dreg_bank #(.WIDTH(W), .CHANNELS(CH)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .EN        (EN),
    .WE        (WE),
    .D         (D),
    .SEL       (SEL),
    .LOCK      (LOCK),
    .UNLOCK    (UNLOCK),
    .Q         (Q),
    .Q_ALL     (Q_ALL),
    .CHG       (CHG),
    .LOCKED    (LOCKED),
    .VIOL      (VIOL),
    .PERR      (PERR),
    .STATE_DBG (STATE_DBG)
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    RST = 1'b1; EN = 1'b1; WE = 4'hF; D = 8'hFF; SEL = 2'd0; LOCK = 1'b0; UNLOCK = 1'b0;

    // Reset with a coincident full-bank write: the write must be discarded.
    step();
    check("rst_q_all",  Q_ALL,  32'h0);
    check("rst_chg",    CHG,    32'h0);
    check("rst_locked", LOCKED, 32'h0);
    check("rst_viol",   VIOL,   32'h0);
    check("rst_q",      Q,      32'h0);
    check("rst_perr",   PERR,   32'h0);

    // Single-channel write.
    RST = 1'b0; EN = 1'b1; WE = 4'b0010; D = 8'hA5;
    step();
    check("wr1_q_all", Q_ALL, 32'h0000_A500);
    check("wr1_chg",   CHG,   32'b0010);
    SEL = 2'd1; #1;
    check("wr1_q_sel1", Q, 32'hA5);

    // EN low: hold.
    EN = 1'b0; D = 8'h3C;
    step();
    check("hold_q_all", Q_ALL, 32'h0000_A500);
    check("hold_chg",   CHG,   32'b0010);

    // Broadcast to channels 0 and 3.
    EN = 1'b1; WE = 4'b1001; D = 8'h5A;
    step();
    check("bc_q_all", Q_ALL, 32'h5A00_A55A);
    check("bc_chg",   CHG,   32'b1011);
    SEL = 2'd3; #1;
    check("bc_q_sel3", Q, 32'h5A);

    // Writing the value already stored must not set CHG.
    WE = 4'b0100; D = 8'h00;
    step();
    check("same_q_all", Q_ALL, 32'h5A00_A55A);
    check("same_chg",   CHG,   32'b1011);

    // LOCK with a coincident write: write accepted, bank locks.
    LOCK = 1'b1; WE = 4'b0001; D = 8'h11;
    step();
    check("lock_q_all",  Q_ALL,     32'h5A00_A511);
    check("lock_locked", LOCKED,    32'h1);
    check("lock_viol",   VIOL,      32'h0);
    check("lock_state",  STATE_DBG, 32'(ST_LOCKED));

    // Write while locked: rejected, VIOL sets.
    LOCK = 1'b0; WE = 4'b0001; D = 8'h22;
    step();
    check("viol_q_all", Q_ALL, 32'h5A00_A511);
    check("viol_viol",  VIOL,  32'h1);
    EN = 1'b0; WE = 4'b0000;

    // Incomplete unlock: one UNLOCK cycle then back to LOCKED.
    UNLOCK = 1'b1;
    step();
    check("arm1_state",  STATE_DBG, 32'(ST_ARMING));
    check("arm1_locked", LOCKED,    32'h1);
    UNLOCK = 1'b0;
    step();
    check("abort_state", STATE_DBG, 32'(ST_LOCKED));

    // Full unlock: two consecutive UNLOCK cycles.
    UNLOCK = 1'b1;
    step();
    step();
    check("unl_locked", LOCKED, 32'h0);
    check("unl_viol",   VIOL,   32'h1);
    UNLOCK = 1'b0;

    // Write after unlock is accepted.
    EN = 1'b1; WE = 4'b0001; D = 8'h33;
    step();
    check("post_unl_q_all", Q_ALL, 32'h5A00_A533);
    SEL = 2'd0; #1;
    check("post_unl_q0", Q, 32'h33);
    EN = 1'b0; WE = 4'b0000;

    // LOCK overrides UNLOCK while ARMING.
    LOCK = 1'b1;
    step();
    LOCK = 1'b0; UNLOCK = 1'b1;
    step();
    check("ovr_arm", STATE_DBG, 32'(ST_ARMING));
    LOCK = 1'b1; UNLOCK = 1'b1;
    step();
    check("ovr_state", STATE_DBG, 32'(ST_LOCKED));

    // Reset mid-sequence from ARMING.
    LOCK = 1'b0; UNLOCK = 1'b1;
    step();
    check("pre_rst_arm", STATE_DBG, 32'(ST_ARMING));
    RST = 1'b1; UNLOCK = 1'b0;
    step();
    check("rst2_state", STATE_DBG, 32'(ST_UNLOCKED));
    check("rst2_q_all", Q_ALL,     32'h0);
    check("rst2_chg",   CHG,       32'h0);
    check("rst2_viol",  VIOL,      32'h0);
    RST = 1'b0;

    // Parity: write 07 to channel 1 then corrupt stored data.
    EN = 1'b1; WE = 4'b0010; D = 8'h07; SEL = 2'd1;
    step();
    EN = 1'b0; WE = 4'b0000;
    check("par_q",    Q,    32'h07);
    check("par_perr", PERR, 32'h0);
`ifdef DREG_BANK_PARITY_EN
    force dut.g_cell[1].u_cell.data_q = 8'h06;
    #1;
    check("par_err_sel1", PERR, 32'h1);
    SEL = 2'd0; #1;
    check("par_err_sel0", PERR, 32'h0);
    release dut.g_cell[1].u_cell.data_q;
`else
    step();
    check("par_off_perr", PERR, 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dreg_bank.md
DREG_BANK -- requirements
Module: dreg_bank

Interface
REQ-001 Parameter WIDTH, default 8: data bits per channel, range 1..32.
REQ-002 Parameter CHANNELS, default 4: number of storage channels, range 2..16.
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 RST  input  1  reset, synchronous, active-high.
REQ-005 EN  input  1  global write enable; no channel is written while low.
REQ-006 WE  input  CHANNELS  per-channel write strobe; bit i selects channel i.
REQ-007 D  input  WIDTH  write data, broadcast to all strobed channels.
REQ-008 SEL  input  $clog2(CHANNELS)  read channel select.
REQ-009 LOCK  input  1  request to freeze the bank.
REQ-010 UNLOCK  input  1  unlock sequence input.
REQ-011 Q  output  WIDTH  contents of channel SEL, combinational from registers.
REQ-012 Q_ALL  output  WIDTH*CHANNELS  all channels flattened, channel 0 in LSBs.
REQ-013 CHG  output  CHANNELS  sticky flag: channel value changed since last reset.
REQ-014 LOCKED  output  1  high in states LOCKED and ARMING.
REQ-015 VIOL  output  1  sticky flag: write attempted while locked.
REQ-016 PERR  output  1  parity error on the selected channel (see Configuration).

Function
REQ-017 Channel i SHALL load D on a rising edge when EN=1, WE[i]=1 and state=UNLOCKED; otherwise it holds.
REQ-018 Write latency SHALL be one edge: the new value is visible on Q/Q_ALL immediately after the capturing edge.
REQ-019 Multiple WE bits set SHALL write D to every selected channel in the same cycle.
REQ-020 SEL >= CHANNELS SHALL drive Q = 0 and PERR = 0.
REQ-021 CHG[i] SHALL set on an accepted write whose D differs from the stored value; it never clears except by reset.
REQ-022 The FSM SHALL have states UNLOCKED, LOCKED and ARMING.
REQ-023 UNLOCKED -> LOCKED when LOCK=1; a write in the same cycle is still accepted.
REQ-024 LOCKED -> ARMING when UNLOCK=1; otherwise stay in LOCKED.
REQ-025 ARMING -> UNLOCKED when UNLOCK=1 on the next cycle; otherwise return to LOCKED.
REQ-026 LOCK=1 in LOCKED or ARMING SHALL force LOCKED, overriding UNLOCK.
REQ-027 VIOL SHALL set on any cycle with EN=1, WE!=0 and state LOCKED or ARMING; no data changes.

Reset
REQ-028 RST=1 at a rising edge SHALL clear all channels to 0, CHG to 0 and VIOL to 0, and set state to UNLOCKED; this overrides every other input.
REQ-029 A write coincident with RST SHALL be discarded, and reset mid-sequence (ARMING) SHALL return the FSM to UNLOCKED.
REQ-030 After reset: Q=0, Q_ALL=0, CHG=0, LOCKED=0, VIOL=0, PERR=0.

Configuration
REQ-031 With macro DREG_BANK_PARITY_EN defined, each channel SHALL store an even-parity bit computed from D at write time.
REQ-032 In that mode, PERR SHALL be high when the stored parity of channel SEL mismatches the parity recomputed from its data.
REQ-033 Without DREG_BANK_PARITY_EN, no parity storage SHALL exist and PERR SHALL be tied to 0.

Structure
REQ-034 Package dreg_bank_pkg SHALL hold the FSM state enum type and the default WIDTH/CHANNELS constants.
REQ-035 Sub-module dreg_cell SHALL implement one channel: data register, optional parity bit and CHG flag; it is instantiated CHANNELS times by generate.

Verification
REQ-036 Reset: RST=1 with D=8'hFF, EN=1, WE=4'hF -> Q_ALL=0 and CHG=0 after the edge.
REQ-037 Write/hold: EN=1, WE=4'b0010, D=8'hA5 -> channel 1 = A5 and CHG=4'b0010; then EN=0, D=8'h3C -> channel 1 stays A5.
REQ-038 Broadcast: EN=1, WE=4'b1001, D=8'h5A -> channels 0 and 3 = 5A; channels 1 and 2 unchanged; SEL=3 gives Q=5A.
REQ-039 Lock: LOCK=1 with a write of D=8'h11 to channel 0 -> write accepted and LOCKED=1. A following write of 8'h22 -> channel 0 stays 11 and VIOL=1.
REQ-040 Unlock sequence: UNLOCK=1 for one cycle then 0 -> returns to LOCKED. UNLOCK=1 for two consecutive cycles -> LOCKED=0, after which a write of 8'h33 is accepted.
REQ-041 Parity (DREG_BANK_PARITY_EN): write 8'h07, then force-flip the stored data bit 0 -> PERR=1 when SEL selects that channel; without the macro, PERR=0 throughout.
